// File: rtl/correlator_slot_ctrl.sv
// -----------------------------------------------------------------------------
// correlator_slot_ctrl
//
// Sequencer for the time-multiplexed cos/sin DSP correlator. Each accepted
// sample strobe starts a walk over TSLICE accumulator slots. One slot is issued
// per clock. Each slot reads its partial sum from the double-buffered SRAM, runs
// through the DSP input and output registers, and is written back DELAY cycles
// after the read. Samples are counted per accumulation block. When a block ends,
// the SRAM bank flips immediately and a one-cycle pulse marks the final
// writeback of the old bank.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active-low (deassertion synchronised upstream)
//   enable     accept new samples when high
//   strobe     one-cycle pulse, new antenna sample valid
//   rd_en      partial-sum SRAM read enable (synchronous read, data next cycle)
//   rd_adr     {bank, slot} read address
//   dsp_en     DSP input-register enable
//   dsp_clr    DSP input-register clear (first sample of a block)
//   dsp_vld    DSP output-register enable
//   wr_en      partial-sum SRAM write enable
//   wr_adr     {bank, slot} write address
//   bank       bank currently accumulating
//   switching  one-cycle pulse, cycle after the last old-bank writeback
//   overflow   sticky, strobe arrived while a sample was still sequencing
//   busy       slot walk or writeback pipeline in flight
//
// FSM states
//   state | meaning
//   IDLE  | waiting for strobe & enable, no slot being issued
//   RUN   | issuing slot slot_q this cycle (read of {bank_q, slot_q})
// -----------------------------------------------------------------------------
module correlator_slot_ctrl #(
   parameter int TSLICE = 12,
   parameter int TBITS  = 4,
   parameter int COUNT  = 10,
   parameter int DELAY  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             strobe,
   output logic             rd_en,
   output logic [TBITS:0]   rd_adr,
   output logic             dsp_en,
   output logic             dsp_clr,
   output logic             dsp_vld,
   output logic             wr_en,
   output logic [TBITS:0]   wr_adr,
   output logic             bank,
   output logic             switching,
   output logic             overflow,
   output logic             busy
);

   localparam logic [TBITS-1:0] LAST_SLOT = TBITS'(TSLICE - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [TBITS-1:0]   slot_q, slot_d;
   logic [COUNT-1:0]   cnt_q, cnt_d;
   logic               bank_q, bank_d;
   logic               ovf_q, ovf_d;

   logic               issue;
   logic               start;
   logic               final_slot;
   logic               block_end;

   // Control pipeline behind the read: stage i is valid i cycles after issue.
   logic [DELAY:1]     vld_sr;
   logic [DELAY:1]     last_sr;
   logic [TBITS:0]     adr_sr [DELAY:1];
   logic               clr_q;
   logic               sw_q;

   assign issue      = (state_q == RUN);
   assign start      = strobe & enable;
   assign final_slot = issue && (slot_q == LAST_SLOT);
   // Final slot of the last sample in a block: the block's last old-bank read.
   assign block_end  = final_slot && (cnt_q == '1);

   // --------------------------------------------------------------------------
   // State register and counters
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
         cnt_q   <= '0;
         bank_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         ovf_q   <= ovf_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            slot_d = '0;
            if (start) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (final_slot) begin
               slot_d = '0;
               // Count advances even when enable has dropped mid-walk: the
               // sample was accepted and its slots all complete.
               cnt_d  = cnt_q + 1'b1;
               // The bank flips now, so a back-to-back sample already targets
               // the new bank. Writes still in the pipeline carry their own
               // bank bit.
               if (cnt_q == '1) begin
                  bank_d = ~bank_q;
               end
               state_d = start ? RUN : IDLE;
            end else begin
               slot_d = slot_q + 1'b1;
               if (strobe) begin
                  ovf_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            slot_d  = '0;
         end
      endcase
   end

   assign rd_en  = issue;
   assign rd_adr = issue ? {bank_q, slot_q} : '0;

   // --------------------------------------------------------------------------
   // Issue-aligned shift registers. Invalid stages carry a zero address, so
   // wr_adr reads as zero whenever wr_en is low.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr  <= '0;
         last_sr <= '0;
         clr_q   <= 1'b0;
         sw_q    <= 1'b0;
         for (int i = 1; i <= DELAY; i++) begin
            adr_sr[i] <= '0;
         end
      end else begin
         vld_sr    <= {vld_sr[DELAY-1:1], issue};
         last_sr   <= {last_sr[DELAY-1:1], block_end};
         clr_q     <= issue && (cnt_q == '0);
         sw_q      <= last_sr[DELAY];
         adr_sr[1] <= rd_adr;
         for (int i = 2; i <= DELAY; i++) begin
            adr_sr[i] <= adr_sr[i-1];
         end
      end
   end

   assign dsp_en    = vld_sr[1];
   assign dsp_clr   = clr_q;
   assign dsp_vld   = vld_sr[2];
   assign wr_en     = vld_sr[DELAY];
   assign wr_adr    = adr_sr[DELAY];
   assign bank      = bank_q;
   assign switching = sw_q;
   assign overflow  = ovf_q;
   assign busy      = issue | (|vld_sr);

endmodule

// File: tb/tb_correlator_slot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_correlator_slot_ctrl
//
// Directed scenarios followed by a randomized phase. A schedule-based reference
// model fills a per-cycle table of expected outputs whenever it accepts a
// sample. Every cycle, the DUT outputs are compared against that table.
// COUNT is reduced to 2 so that block wraps and bank switches occur often.
// -----------------------------------------------------------------------------
module tb_correlator_slot_ctrl;

   localparam int TS  = 12;
   localparam int TB  = 4;
   localparam int CN  = 2;
   localparam int DL  = 3;
   localparam int BLK = 1 << CN;
   localparam int NC  = 4096;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          strobe;
   logic          rd_en;
   logic [TB:0]   rd_adr;
   logic          dsp_en;
   logic          dsp_clr;
   logic          dsp_vld;
   logic          wr_en;
   logic [TB:0]   wr_adr;
   logic          bank;
   logic          switching;
   logic          overflow;
   logic          busy;

   always #5 clk = ~clk;

   correlator_slot_ctrl #(
      .TSLICE(TS), .TBITS(TB), .COUNT(CN), .DELAY(DL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .strobe    (strobe),
      .rd_en     (rd_en),
      .rd_adr    (rd_adr),
      .dsp_en    (dsp_en),
      .dsp_clr   (dsp_clr),
      .dsp_vld   (dsp_vld),
      .wr_en     (wr_en),
      .wr_adr    (wr_adr),
      .bank      (bank),
      .switching (switching),
      .overflow  (overflow),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;

   // Expected-output schedule, indexed by cycle number
   bit          e_rd  [NC];
   logic [TB:0] e_radr[NC];
   bit          e_en  [NC];
   bit          e_clr [NC];
   bit          e_vld [NC];
   bit          e_wr  [NC];
   logic [TB:0] e_wadr[NC];
   bit          e_sw  [NC];

   int k          = 0;
   int walk_start = -1;
   int walk_end   = -1;
   int nsamp      = 0;
   int ovf_at     = -1;
   int flip_at    = -1;
   bit mbank      = 1'b0;
   bit in_rst     = 1'b1;

   // DUT-observed tallies for the directed scenarios
   int t_rd, t_busy, t_clr, t_wr, t_sw, cur_run, max_run;

   task automatic clr_tally();
      t_rd = 0; t_busy = 0; t_clr = 0; t_wr = 0; t_sw = 0;
      cur_run = 0; max_run = 0;
   endtask

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Accept one sample whose first slot is issued in cycle c.
   task automatic schedule(input int c);
      bit b, clr;
      b   = ((nsamp / BLK) % 2) == 1;
      clr = (nsamp % BLK) == 0;
      for (int i = 0; i < TS; i++) begin
         if (c + i + DL < NC) begin
            e_rd  [c+i]      = 1'b1;
            e_radr[c+i]      = {b, 4'(i)};
            e_en  [c+i+1]    = 1'b1;
            e_clr [c+i+1]    = clr;
            e_vld [c+i+2]    = 1'b1;
            e_wr  [c+i+DL]   = 1'b1;
            e_wadr[c+i+DL]   = {b, 4'(i)};
         end
      end
      if ((nsamp % BLK) == BLK - 1) begin
         if (c + TS + DL < NC) e_sw[c + TS - 1 + DL + 1] = 1'b1;
         flip_at = c + TS;
      end
      walk_start = c;
      walk_end   = c + TS - 1;
      nsamp++;
   endtask

   // Apply the inputs sampled at the end of cycle k.
   task automatic model_in(input bit s, input bit e);
      bit walking, fin;
      walking = (walk_start >= 0) && (k >= walk_start) && (k <= walk_end);
      fin     = walking && (k == walk_end);
      if (s && e && (!walking || fin)) begin
         schedule(k + 1);
      end else if (s && walking && !fin && ovf_at < 0) begin
         ovf_at = k + 1;
      end
   endtask

   task automatic cycle(input bit s, input bit e);
      logic [18:0] obs, expv;
      bit busy_e, ovf_e;
      @(negedge clk);
      if (k >= NC) begin
         $display("FAIL schedule overrun cyc %0d", k);
         $fatal(1);
      end
      if (k == flip_at) mbank = ~mbank;
      ovf_e  = (ovf_at >= 0) && (k >= ovf_at);
      busy_e = e_rd[k] | e_en[k] | e_vld[k] | e_wr[k];
      expv = {e_rd[k], e_radr[k], e_en[k], e_clr[k], e_vld[k], e_wr[k],
              e_wadr[k], mbank, e_sw[k], ovf_e, busy_e};
      obs  = {rd_en, rd_adr, dsp_en, dsp_clr, dsp_vld, wr_en,
              wr_adr, bank, switching, overflow, busy};
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL outputs cyc %0d got %h expected %h", k, obs, expv);
      end
      t_rd   += int'(rd_en);
      t_busy += int'(busy);
      t_clr  += int'(dsp_clr);
      t_wr   += int'(wr_en);
      t_sw   += int'(switching);
      if (rd_en === 1'b1) begin
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
      end else begin
         cur_run = 0;
      end
      strobe = s;
      enable = e;
      if (!in_rst) model_in(s, e);
      k++;
   endtask

   task automatic idle(input int n, input bit e);
      repeat (n) cycle(1'b0, e);
   endtask

   // Called at a negedge, right after a cycle; everything from cycle k onward is discarded.
   task automatic apply_reset(input int n);
      rst_n  = 1'b0;
      in_rst = 1'b1;
      for (int j = k; j < NC; j++) begin
         e_rd[j] = 1'b0; e_radr[j] = '0; e_en[j] = 1'b0; e_clr[j] = 1'b0;
         e_vld[j] = 1'b0; e_wr[j] = 1'b0; e_wadr[j] = '0; e_sw[j] = 1'b0;
      end
      walk_start = -1; walk_end = -1; nsamp = 0;
      ovf_at = -1; flip_at = -1; mbank = 1'b0;
      repeat (n) cycle(1'b0, 1'b0);
      rst_n  = 1'b1;
      in_rst = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      strobe = 1'b0;
      enable = 1'b0;
      for (int j = 0; j < NC; j++) begin
         e_radr[j] = '0; e_wadr[j] = '0;
      end
      clr_tally();
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      rst_n  = 1'b1;
      in_rst = 1'b0;

      // 1: single strobe after reset
      clr_tally();
      cycle(1'b1, 1'b1);
      idle(20, 1'b1);
      check("t1_busy_cycles", t_busy, 15);
      check("t1_rd_cycles",   t_rd,   12);
      check("t1_clr_cycles",  t_clr,  12);
      check("t1_wr_cycles",   t_wr,   12);

      // 2: three back-to-back samples
      apply_reset(2);
      clr_tally();
      cycle(1'b1, 1'b1); idle(11, 1'b1);
      cycle(1'b1, 1'b1); idle(11, 1'b1);
      cycle(1'b1, 1'b1); idle(20, 1'b1);
      check("t2_rd_run",   max_run,       36);
      check("t2_clr",      t_clr,         12);
      check("t2_overflow", int'(overflow), 0);

      // 3: strobe at slot 5 is ignored and sets overflow
      apply_reset(2);
      clr_tally();
      cycle(1'b1, 1'b1); idle(5, 1'b1);
      cycle(1'b1, 1'b1); idle(20, 1'b1);
      check("t3_overflow", int'(overflow), 1);
      check("t3_rd",       t_rd,           12);
      cycle(1'b1, 1'b1); idle(20, 1'b1);
      check("t3_rd2",      t_rd,           24);
      check("t3_clr",      t_clr,          12);
      check("t3_ovf_sticky", int'(overflow), 1);

      // 4: block wrap with COUNT=2, five back-to-back samples
      apply_reset(2);
      clr_tally();
      repeat (5) begin
         cycle(1'b1, 1'b1); idle(11, 1'b1);
      end
      idle(20, 1'b1);
      check("t4_switching", t_sw,        1);
      check("t4_bank",      int'(bank),  1);
      check("t4_rd_run",    max_run,     60);
      check("t4_clr",       t_clr,       24);

      // 5: enable dropped at slot 3 of the second sample
      apply_reset(2);
      clr_tally();
      cycle(1'b1, 1'b1); idle(20, 1'b1);
      cycle(1'b1, 1'b1); idle(3, 1'b1);
      idle(20, 1'b0);
      cycle(1'b1, 1'b0); idle(15, 1'b0);
      cycle(1'b1, 1'b0); idle(15, 1'b0);
      check("t5_rd_held", t_rd, 24);
      cycle(1'b1, 1'b1); idle(20, 1'b1);
      check("t5_rd_resume", t_rd,  36);
      check("t5_clr",       t_clr, 12);

      // 6: reset at slot 7
      apply_reset(2);
      clr_tally();
      cycle(1'b1, 1'b1); idle(7, 1'b1);
      cycle(1'b0, 1'b1);
      apply_reset(2);
      idle(20, 1'b1);
      check("t6_wr_before_rst", t_wr, 5);
      clr_tally();
      cycle(1'b1, 1'b1); idle(20, 1'b1);
      check("t6_clr_after_rst", t_clr,      12);
      check("t6_bank",          int'(bank), 0);

      // Randomized phase
      apply_reset(2);
      for (int n = 0; n < 1500; n++) begin
         bit s, e;
         s = ($urandom_range(0, 5) == 0);
         e = ($urandom_range(0, 7) != 0);
         if (k == walk_end && $urandom_range(0, 1) == 1) s = 1'b1;
         cycle(s, e);
         if ($urandom_range(0, 299) == 0) apply_reset($urandom_range(1, 3));
      end
      idle(20, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
